// File: rtl/subtractor_16bit_seq.sv
// Chunk-serial subtractor: computes diff = a - b - borrow_in, CHUNK_WIDTH bits
// per clock, LSB chunk first, behind a start/busy/done handshake.
//
// Handshake: start is sampled on every rising edge and is accepted only in
// IDLE or DONE. Acceptance latches a, b and borrow_in, raises busy and drops
// done on that edge. busy stays high for exactly N edges. On the last of
// those edges done rises, and diff/borrow_out/overflow are updated together.
// done then stays high until the next accepted start or reset. start seen
// while busy is ignored.
module subtractor_16bit_seq #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 borrow_out,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int N     = BIT_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = BIT_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] a_q;
  logic [BIT_WIDTH-1:0] b_q;
  logic                 borrow_q;
  logic [BIT_WIDTH-1:0] res_q;

  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   chunk_sub;
  logic [BIT_WIDTH-1:0]   res_next;
  logic                   last_chunk;

  assign state_dbg  = state;
  assign last_chunk = (cnt == CNT_W'(N - 1));

  // Subtract the current chunk with the running borrow and merge it into the result.
  always_comb begin
    a_chunk   = a_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    b_chunk   = b_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    chunk_sub = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_WIDTH{1'b0}}, borrow_q};
    res_next  = res_q;
    res_next[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sub[CHUNK_WIDTH-1:0];
  end

  // Control FSM, operand/partial-result registers and the registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      borrow_q   <= 1'b0;
      res_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= borrow_in;
            cnt      <= '0;
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          res_q    <= res_next;
          borrow_q <= chunk_sub[CHUNK_WIDTH];
          cnt      <= cnt + 1'b1;
          if (last_chunk) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= chunk_sub[CHUNK_WIDTH];
            // Operands of differing sign whose result sign differs from the minuend.
            overflow   <= (a_q[MSB] != b_q[MSB]) && (res_next[MSB] != a_q[MSB]);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
